// File: rtl/mult_div_sequencer.sv
// Sequential 32-bit signed multiply/divide unit for the control unit.
// It uses 32 shift-add or restoring shift-subtract steps and writes HI/LO on the edge entering FINISH.
module mult_div_sequencer (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] work_hi_reg, work_hi_next;
  logic [31:0] work_lo_reg, work_lo_next;
  logic [31:0] operand_reg, operand_next;
  logic        neg_main_reg, neg_main_next;
  logic        neg_rem_reg, neg_rem_next;
  logic        dz_reg, dz_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;

  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_step, prod_signed;
  logic [32:0] div_shift, div_diff;
  logic [31:0] rem_step, quo_step, quo_signed, rem_signed;

  // During a multiply, {work_hi, work_lo} is the product/multiplier pair.
  // During a divide, work_hi is the partial remainder and work_lo is the dividend/quotient.
  always_comb begin
    a_mag = a[31] ? (32'd0 - a) : a;
    b_mag = b[31] ? (32'd0 - b) : b;

    mul_sum  = {1'b0, work_hi_reg} + (work_lo_reg[0] ? {1'b0, operand_reg} : 33'd0);
    mul_step = {mul_sum, work_lo_reg[31:1]};

    div_shift = {work_hi_reg, work_lo_reg[31]};
    div_diff  = div_shift - {1'b0, operand_reg};
    if (!div_diff[32]) begin
      rem_step = div_diff[31:0];
      quo_step = {work_lo_reg[30:0], 1'b1};
    end else begin
      rem_step = div_shift[31:0];
      quo_step = {work_lo_reg[30:0], 1'b0};
    end

    prod_signed = neg_main_reg ? (64'd0 - mul_step) : mul_step;
    quo_signed  = neg_main_reg ? (32'd0 - quo_step) : quo_step;
    rem_signed  = neg_rem_reg  ? (32'd0 - rem_step) : rem_step;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= 5'd0;
      work_hi_reg  <= 32'd0;
      work_lo_reg  <= 32'd0;
      operand_reg  <= 32'd0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      dz_reg       <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      work_hi_reg  <= work_hi_next;
      work_lo_reg  <= work_lo_next;
      operand_reg  <= operand_next;
      neg_main_reg <= neg_main_next;
      neg_rem_reg  <= neg_rem_next;
      dz_reg       <= dz_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    work_hi_next  = work_hi_reg;
    work_lo_next  = work_lo_reg;
    operand_next  = operand_reg;
    neg_main_next = neg_main_reg;
    neg_rem_next  = neg_rem_reg;
    dz_next       = dz_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    busy          = 1'b0;
    done          = 1'b0;
    div_zero      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          count_next    = 5'd0;
          work_hi_next  = 32'd0;
          neg_main_next = a[31] ^ b[31];
          neg_rem_next  = a[31];
          dz_next       = 1'b0;
          if (!op) begin
            state_next   = MUL_RUN;
            work_lo_next = b_mag;
            operand_next = a_mag;
          end else if (b != 32'd0) begin
            state_next   = DIV_RUN;
            work_lo_next = a_mag;
            operand_next = b_mag;
          end else begin
            // A divide by zero skips the datapath, so HI/LO keep their old values.
            state_next = FINISH;
            dz_next    = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        busy         = 1'b1;
        work_hi_next = mul_step[63:32];
        work_lo_next = mul_step[31:0];
        count_next   = count_reg + 5'd1;
        if (count_reg == 5'd31) begin
          state_next = FINISH;
          hi_next    = prod_signed[63:32];
          lo_next    = prod_signed[31:0];
        end
      end
      DIV_RUN: begin
        busy         = 1'b1;
        work_hi_next = rem_step;
        work_lo_next = quo_step;
        count_next   = count_reg + 5'd1;
        if (count_reg == 5'd31) begin
          state_next = FINISH;
          hi_next    = rem_signed;
          lo_next    = quo_signed;
        end
      end
      FINISH: begin
        done       = 1'b1;
        div_zero   = dz_reg;
        dz_next    = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: doc/mult_div_sequencer.md
MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

Interface
REQ-001 Clk  input  1  clock; all state changes on the rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high; clock Clk.
REQ-003 start  input  1  request pulse from the control unit; sampled only in IDLE.
REQ-004 op  input  1  operation select: 0 = MULT, 1 = DIV; sampled with start.
REQ-005 a  input  32  operand A (multiplicand or dividend), signed two's complement.
REQ-006 b  input  32  operand B (multiplier or divisor), signed two's complement.
REQ-007 busy  output  1  high while an operation is in progress (MUL_RUN, DIV_RUN).
REQ-008 done  output  1  single-cycle completion pulse (FINISH state).
REQ-009 div_zero  output  1  high with done when a DIV had b = 0; low otherwise.
REQ-010 hi  output  32  HI register: product[63:32] or remainder.
REQ-011 lo  output  32  LO register: product[31:0] or quotient.

Function
REQ-012 States SHALL be IDLE, MUL_RUN, DIV_RUN and FINISH, encoded in one registered state variable.
REQ-013 IDLE with start = 1 and op = 0 SHALL go to MUL_RUN; with op = 1 and b != 0, DIV_RUN; with op = 1 and b = 0, FINISH.
REQ-014 On start acceptance, a, b and op SHALL be latched; later changes to a, b, op have no effect on the running operation.
REQ-015 Operands SHALL be converted to magnitudes and result signs recorded at acceptance.
REQ-016 MUL_RUN SHALL perform one shift-add step per cycle for exactly 32 cycles (5-bit counter 0..31), then go to FINISH.
REQ-017 DIV_RUN SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FINISH.
REQ-018 MULT result: 64-bit signed product; negated when the operand signs differ; hi = [63:32], lo = [31:0].
REQ-019 DIV result: quotient truncated toward zero into lo; remainder with the dividend's sign into hi.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield lo = 0x80000000, hi = 0x00000000 (no trap).
REQ-021 hi and lo SHALL update only on the edge entering FINISH; otherwise they hold.
REQ-022 Divide by zero: hi and lo SHALL hold their previous values; div_zero = 1 for the FINISH cycle only.
REQ-023 FINISH SHALL last exactly one cycle with done = 1 and busy = 0, then return unconditionally to IDLE.
REQ-024 start in MUL_RUN, DIV_RUN or FINISH SHALL be ignored, with no queuing.
REQ-025 Latency: start sampled at edge k -> busy high from edge k+1 to k+33; done high from edge k+33 to k+34 (DIV by zero: done at k+1).
REQ-026 busy, done and div_zero SHALL be decoded from state only (Moore outputs).

Reset
REQ-027 reset = 1 at a rising edge SHALL force IDLE and clear hi, lo, the counter and internal registers to 0; busy = done = div_zero = 0.
REQ-028 reset SHALL take priority over start and over any in-progress operation; a partial result is discarded and hi/lo read 0.
REQ-029 The first start SHALL be accepted in the first cycle after reset deasserts.

Verification
REQ-030 MULT a = 7, b = 0xFFFFFFFD (-3) -> done at start edge + 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
REQ-031 MULT a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000; busy high for exactly 32 cycles.
REQ-032 DIV a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div_zero = 0.
REQ-033 Preload hi/lo with MULT 3*5 (lo = 15), then DIV a = 9, b = 0 -> done and div_zero high on the next cycle; hi = 0, lo = 15 unchanged.
REQ-034 MULT 2*3 started; start with op = 1 pulsed at cycle 10 -> ignored; single done with lo = 6, hi = 0.
REQ-035 DIV 100/7 started; reset asserted at cycle 15 for 1 cycle -> IDLE, hi = lo = 0, no done; new DIV 100/7 -> lo = 14, hi = 2.
